// File: rtl/inst_mem_loader_pkg.sv
// ============================================================================
//  Module   : inst_mem_loader_pkg
//  Purpose  : Shared definitions for the instruction-memory program loader:
//             loader FSM state encoding, stream framing constants and the
//             header validity check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package inst_mem_loader_pkg;

    // Stream framing: a 2-byte big-endian word count, then 4 bytes per word.
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int HDR_W          = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_BYTES  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    // A program must contain at least one word and must fit in the memory.
    function automatic logic header_ok(input logic [HDR_W-1:0] n, input int depth);
        return (n != '0) && (int'(n) <= depth);
    endfunction

endpackage : inst_mem_loader_pkg

`default_nettype wire

// File: rtl/inst_mem_loader_byte_word_packer.sv
// ============================================================================
//  Module   : inst_mem_loader_byte_word_packer
//  Purpose  : Assembles big-endian words from a byte stream (first byte ends
//             up in the most significant position).
//  Ports    : clk, rst        clock / async active-high reset
//             clear           drop any partial word, restart at byte 0
//             load            accept byte_in this cycle
//             byte_in         stream byte
//             next_word       word including byte_in (valid with word_ready)
//             word_ready      this load completes a word
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module inst_mem_loader_byte_word_packer
    import inst_mem_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] next_word,
    output logic              word_ready
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [WORD_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;

    // The completed word is offered combinationally so the loader can
    // register it on the same edge that accepts the final byte.
    assign next_word  = {r_shift[WORD_W-9:0], byte_in};
    assign word_ready = load && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (load) begin
            r_shift <= next_word;
            r_idx   <= r_idx + 1'b1;   // wraps to 0 after the last byte
        end
    end

endmodule : inst_mem_loader_byte_word_packer

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ============================================================================
//  Module   : inst_mem_loader
//  Purpose  : Runtime program loader for the instruction memory. Receives a
//             byte stream (2-byte word count N, then N big-endian words),
//             writes the words from address 0 upward and holds the CPU until
//             the whole program is in memory.
//  Ports    : clk, rst              clock / async active-high reset
//             start                 pulse: begin a load (IDLE/DONE/ERR only)
//             byte_in/valid/ready   byte stream handshake
//             im_we/addr/wdata      instruction-memory write port
//             cpu_hold              1 = CPU held, 0 = CPU may run
//             done, error           load complete / header rejected (levels)
//             word_count            words written this session
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    loader_state_t     r_state;
    logic [7:0]        r_hdr_hi;
    logic [HDR_W-1:0]  r_n;

    logic              w_xfer;
    logic              w_start_ok;
    logic [HDR_W-1:0]  w_hdr_n;
    logic [15:0]       w_count_next;
    logic              w_pack_clear;
    logic              w_pack_load;
    logic [WORD_W-1:0] w_next_word;
    logic              w_word_ready;

    assign w_xfer       = byte_valid && byte_ready;
    assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                    (r_state == ST_ERR));
    assign w_hdr_n      = {r_hdr_hi, byte_in};
    assign w_count_next = word_count + 16'd1;
    // Any partial word is dropped once a new header has been accepted.
    assign w_pack_clear = (r_state == ST_HDR_LO) && w_xfer;
    assign w_pack_load  = (r_state == ST_BYTES) && w_xfer;

    inst_mem_loader_byte_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_pack_clear),
        .load       (w_pack_load),
        .byte_in    (byte_in),
        .next_word  (w_next_word),
        .word_ready (w_word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hdr_hi   <= '0;
            r_n        <= '0;
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            im_we <= 1'b0;   // single-cycle pulse unless set below
            if (w_start_ok) begin
                r_state    <= ST_HDR_HI;
                byte_ready <= 1'b1;
                cpu_hold   <= 1'b1;
                done       <= 1'b0;
                error      <= 1'b0;
                word_count <= '0;
                im_addr    <= '0;
            end else begin
                case (r_state)
                    ST_HDR_HI: begin
                        if (w_xfer) begin
                            r_hdr_hi <= byte_in;
                            r_state  <= ST_HDR_LO;
                        end
                    end
                    ST_HDR_LO: begin
                        if (w_xfer) begin
                            if (header_ok(w_hdr_n, DEPTH)) begin
                                r_n     <= w_hdr_n;
                                im_addr <= '0;
                                r_state <= ST_BYTES;
                            end else begin
                                byte_ready <= 1'b0;
                                error      <= 1'b1;
                                r_state    <= ST_ERR;
                            end
                        end
                    end
                    ST_BYTES: begin
                        if (w_word_ready) begin
                            byte_ready <= 1'b0;
                            im_we      <= 1'b1;
                            im_wdata   <= w_next_word;
                            r_state    <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        word_count <= w_count_next;
                        if (w_count_next == r_n) begin
                            // The address is left on the last written word so
                            // it never points past DEPTH-1 after a full load.
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            im_addr    <= im_addr + ADDR_W'(1);
                            byte_ready <= 1'b1;
                            r_state    <= ST_BYTES;
                        end
                    end
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        // Wait for start, handled above.
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule : inst_mem_loader

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ============================================================================
//  Module   : tb_inst_mem_loader
//  Purpose  : Self-checking bench for inst_mem_loader. Expected memory writes
//             are queued as stimulus is driven and compared as the loader
//             issues them.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_mem_loader;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [WORD_W-1:0] im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic [ADDR_W-1:0]        last_we_addr;
    logic [ADDR_W+WORD_W-1:0] exp_q[$];
    logic [ADDR_W+WORD_W-1:0] mon_e;

    inst_mem_loader #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && im_we) begin
            n_writes++;
            last_we_addr = im_addr;
            check("we_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("we_addr", 32'(im_addr), 32'(mon_e[ADDR_W+WORD_W-1:WORD_W]));
                check("we_data", im_wdata, mon_e[WORD_W-1:0]);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_im_we"},      32'(im_we),      32'd0);
        check({tag, "_im_addr"},    32'(im_addr),    32'd0);
        check({tag, "_im_wdata"},   im_wdata,        32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit keep);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        if (!keep) byte_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) begin
            byte_valid = 1'b0;
            byte_in    = 8'h5A;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        send_byte(b, gaps);
    endtask

    task automatic wait_end(input int maxc);
        int n = 0;
        while (!done && !error && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", 32'(done | error), 32'd1);
    endtask

    task automatic load_program(input logic [15:0] n, input logic [31:0] words[$],
                                input bit gaps);
        foreach (words[i]) exp_q.push_back({ADDR_W'(i), words[i]});
        pulse_start();
        send_b(n[15:8], gaps);
        send_b(n[7:0], gaps);
        foreach (words[i]) begin
            logic [31:0] w;
            w = words[i];
            send_b(w[31:24], gaps);
            send_b(w[23:16], gaps);
            send_b(w[15:8], gaps);
            send_b(w[7:0], gaps);
            check("we_latency", 32'(im_we), 32'd1);
        end
        byte_valid = 1'b0;
        wait_end(200);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] prog2[$];
        logic [31:0] big[$];
        int          w0;

        rst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("por");

        // Reset in the middle of a word; next session must use fresh bytes.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst_rel");
        load_program(16'd1, '{32'h11223344}, 1'b0);
        check("rst_done", 32'(done), 32'd1);

        // Basic two-word program.
        prog2 = '{32'h20080005, 32'h01095020};
        load_program(16'd2, prog2, 1'b0);
        check("basic_done",       32'(done),       32'd1);
        check("basic_cpu_hold",   32'(cpu_hold),   32'd0);
        check("basic_word_count", 32'(word_count), 32'd2);
        check("basic_byte_ready", 32'(byte_ready), 32'd0);

        // Same program with random gaps and valid held high through WRITE.
        for (int r = 0; r < 3; r++) begin
            load_program(16'd2, prog2, 1'b1);
            check("gap_done",       32'(done),       32'd1);
            check("gap_word_count", 32'(word_count), 32'd2);
        end

        // Bad headers.
        w0 = n_writes;
        load_program(16'd0, '{}, 1'b0);
        check("hdr0_error",    32'(error),    32'd1);
        check("hdr0_cpu_hold", 32'(cpu_hold), 32'd1);
        check("hdr0_done",     32'(done),     32'd0);
        load_program(16'd257, '{}, 1'b0);
        check("hdr257_error", 32'(error),    32'd1);
        check("hdr257_ready", 32'(byte_ready), 32'd0);
        check("hdr_no_write", 32'(n_writes - w0), 32'd0);

        // Full depth.
        for (int i = 0; i < DEPTH; i++) big.push_back(32'hC0DE0000 ^ (i * 32'h00010203));
        w0 = n_writes;
        load_program(16'(DEPTH), big, 1'b0);
        check("full_done",       32'(done),           32'd1);
        check("full_word_count", 32'(word_count),     32'(DEPTH));
        check("full_writes",     32'(n_writes - w0),  32'(DEPTH));
        check("full_last_addr",  32'(last_we_addr),   32'hFF);

        // start during BYTES is ignored.
        foreach (prog2[i]) exp_q.push_back({ADDR_W'(i), prog2[i]});
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(prog2[0][31:24], 1'b0);
        send_byte(prog2[0][23:16], 1'b0);
        pulse_start();
        check("ign_start_ready", 32'(byte_ready), 32'd1);
        send_byte(prog2[0][15:8], 1'b0);
        send_byte(prog2[0][7:0], 1'b0);
        for (int s = 24; s >= 0; s -= 8) send_byte(8'(prog2[1] >> s), 1'b0);
        wait_end(200);
        check("ign_done",       32'(done),       32'd1);
        check("ign_word_count", 32'(word_count), 32'd2);

        // start in DONE begins a fresh session that overwrites address 0 only.
        pulse_start();
        check("restart_done",     32'(done),       32'd0);
        check("restart_cpu_hold", 32'(cpu_hold),   32'd1);
        check("restart_count",    32'(word_count), 32'd0);
        check("restart_ready",    32'(byte_ready), 32'd1);
        w0 = n_writes;
        exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int s = 24; s >= 0; s -= 8) send_byte(8'(32'hDEADBEEF >> s), 1'b0);
        wait_end(200);
        check("restart_writes",    32'(n_writes - w0), 32'd1);
        check("restart_last_addr", 32'(last_we_addr),  32'd0);
        check("restart_count_end", 32'(word_count),    32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_inst_mem_loader

`default_nettype wire
